dcache_data_sched: RTL and testbench
====================================

Name: dcache_data_sched

Overview:
- Scheduler for the L1 data-array access port.
- Shares one array request slot between N requesters (e.g. 0 = refill/writeback, 1 = replay, 2 = load pipe) using round-robin arbitration.
- Locks the port to one requester for multi-beat bursts (refill/evict lines).
- Issues a registered read-response tag one cycle after each accepted read, so the consumer knows which requester owns the returning data.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 12, array row/word address width.
- WAYS, 8, way_en one-hot width.
- BEATS, 4, beats per locked burst (power of 2, >= 2).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- io_req_valid  in  N_REQ  per-requester request valid.
- io_req_ready  out  N_REQ  per-requester accept.
- io_req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- io_req_way_en  in  N_REQ*WAYS  packed way enables.
- io_req_write  in  N_REQ  1 = write, 0 = read.
- io_req_burst  in  N_REQ  1 = first beat of a BEATS-long locked burst.
- io_out_valid  out  1  request presented to the array.
- io_out_ready  in  1  array accepts this cycle (0 = bank conflict/stall).
- io_out_addr  out  ADDR_W  muxed address.
- io_out_way_en  out  WAYS  muxed way enable.
- io_out_write  out  1  muxed write flag.
- io_out_src  out  clog2(N_REQ)  index of the granted requester.
- io_resp_valid  out  1  registered: a read was accepted last cycle.
- io_resp_src  out  clog2(N_REQ)  registered source of that read.

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is asynchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = N_REQ-1, so requester 0 wins first; beat_cnt = 0.
  - io_resp_valid = 0; io_resp_src = 0.
  - Combinational outputs follow from these values.
- Fire: `fire = io_out_valid & io_out_ready`.
- IDLE:
  - Grant goes to the first valid requester scanning (rr_ptr+1) mod N_REQ upward with wrap.
  - io_out_valid = OR of io_req_valid.
  - io_req_ready[i] = grant[i] & io_out_ready. All other readies are 0.
  - On fire: rr_ptr <= granted index.
  - If fire and the granted requester's burst = 1: state <= LOCKED, lock_src <= index, beat_cnt <= 1.
- LOCKED:
  - Only lock_src is eligible. io_out_valid = io_req_valid[lock_src].
  - Other requesters see ready = 0 regardless of their valid.
  - The burst bit is ignored while LOCKED.
  - On fire: beat_cnt increments.
  - On the fire where beat_cnt == BEATS-1: state <= IDLE and beat_cnt <= 0. rr_ptr stays lock_src.
  - The locked requester deasserting valid mid-burst holds the lock, with no timeout.
- Output mux:
  - When io_out_valid = 1, addr/way_en/write/src come from the granted requester.
  - When io_out_valid = 0, all output fields are driven to 0.
- Stalls: io_out_ready = 0 leaves state, rr_ptr and beat_cnt unchanged. The grant may change next cycle in IDLE if valids change.
- Response tag: io_resp_valid <= fire & ~io_out_write; io_resp_src <= io_out_src. Latency is exactly 1 cycle and there is no backpressure.
- Combinational path: the only comb path from io_out_ready is to io_req_ready. io_out_valid does not depend on io_out_ready.
- Reset mid-burst: returns immediately to IDLE; any pending io_resp_valid is cleared.

Optional Feature:
- Macro: DATA_SCHED_PERF_EN.
- Defined: adds output io_perf_conflicts (16 bits), a counter with these rules:
  - Increments each cycle in which at least 2 requesters are valid, or any non-lock_src requester is valid while LOCKED.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package dcache_data_sched_pkg:
  - state enum {IDLE, LOCKED};
  - SRC_W = clog2(N_REQ) helper;
  - default BEATS constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable by other cache arbiters.

Test Plan:
- Post-reset, valid = 3'b111, out_ready = 1, no burst -> grants 0,1,2,0 on consecutive cycles. resp_valid is asserted the cycle after each read with src 0,1,2,0.
- Valid = 3'b101, out_ready = 0 for 3 cycles, then 1 -> src stays 0 and ready = 3'b000 during the stall. Grant to 0 with ready = 3'b001 on cycle 4, then grant to 2.
- Requester 1 issues a burst write (burst = 1 on beat 0) while 0 and 2 stay valid -> 4 consecutive grants to src 1. ready[0] and ready[2] stay 0. No resp_valid, since these are writes. Back in IDLE, requester 2 is granted next.
- In LOCKED with lock_src = 1, drop valid[1] for 2 cycles -> io_out_valid = 0 and no grant to others. The burst completes after the 4th accepted beat.
- Assert reset after beat 2 of a burst -> state IDLE, rr_ptr = N_REQ-1, resp_valid = 0. The next grant goes to the lowest valid index.
- With DATA_SCHED_PERF_EN defined: 10 cycles with valid = 3'b011 and out_ready = 0 -> io_perf_conflicts = 10. The counter saturates at 16'hFFFF in a long run.

Source files
------------

// File: rtl/dcache_data_sched_pkg.sv
// Shared types and constants for the L1 data-array port scheduler.
// The optional perf counter is enabled with DATA_SCHED_PERF_EN.
package dcache_data_sched_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEFAULT_BEATS = 4;

  // Source-index width; a single requester still needs one bit.
  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcache_data_sched_rr_pick.sv
// Combinational round-robin picker: first valid bit scanning upward from ptr+1 with wrap.
// Reusable by other cache arbiters.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Priority scan, written without branches so every path assigns every bit.
  always_comb begin
    int unsigned pos;
    logic        hit;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos        = (int'(ptr) + k) % N;
      hit        = valid[pos] & ~any;
      grant[pos] = hit;
      idx        = hit ? IDX_W'(pos) : idx;
      any        = any | hit;
    end
  end

endmodule

// File: rtl/dcache_data_sched.sv
// L1 data-array port scheduler: round-robin grant, burst lock, 1-cycle read response tag.
// Define DATA_SCHED_PERF_EN to add the io_perf_conflicts saturating counter.
module dcache_data_sched
  import dcache_data_sched_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 12,
  parameter int WAYS   = 8,
  parameter int BEATS  = DEFAULT_BEATS,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        io_req_valid,
  output logic [N_REQ-1:0]        io_req_ready,
  input  logic [N_REQ*ADDR_W-1:0] io_req_addr,
  input  logic [N_REQ*WAYS-1:0]   io_req_way_en,
  input  logic [N_REQ-1:0]        io_req_write,
  input  logic [N_REQ-1:0]        io_req_burst,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [ADDR_W-1:0]       io_out_addr,
  output logic [WAYS-1:0]         io_out_way_en,
  output logic                    io_out_write,
  output logic [SRC_W-1:0]        io_out_src,
  output logic                    io_resp_valid,
  output logic [SRC_W-1:0]        io_resp_src
`ifdef DATA_SCHED_PERF_EN
  ,
  output logic [15:0]             io_perf_conflicts
`endif
);

  localparam int CNT_W = $clog2(BEATS);

  state_t             state_r, state_n;
  logic [SRC_W-1:0]   lock_src_r, lock_src_n;
  logic [SRC_W-1:0]   rr_ptr_r, rr_ptr_n;
  logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_n;
  logic               resp_valid_r;
  logic [SRC_W-1:0]   resp_src_r;

  logic [N_REQ-1:0]   pick_grant_s;
  logic [SRC_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [N_REQ-1:0]   lock_oh_s;
  logic [N_REQ-1:0]   grant_s;
  logic [SRC_W-1:0]   src_s;
  logic               out_valid_s;
  logic               fire_s;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_rr_pick (
    .valid (io_req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign lock_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << lock_src_r;

  // Grant selection; a locked port only ever offers the lock owner.
  always_comb begin
    grant_s     = '0;
    src_s       = '0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        grant_s     = pick_grant_s;
        src_s       = pick_any_s ? pick_idx_s : '0;
        out_valid_s = pick_any_s;
      end
      LOCKED: begin
        out_valid_s = io_req_valid[lock_src_r];
        grant_s     = out_valid_s ? lock_oh_s : '0;
        src_s       = out_valid_s ? lock_src_r : '0;
      end
      default: begin
        grant_s     = '0;
        src_s       = '0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign fire_s        = out_valid_s & io_out_ready;
  assign io_req_ready  = grant_s & {N_REQ{io_out_ready}};
  assign io_out_valid  = out_valid_s;
  assign io_out_src    = src_s;
  assign io_out_addr   = out_valid_s ? io_req_addr[src_s*ADDR_W +: ADDR_W] : '0;
  assign io_out_way_en = out_valid_s ? io_req_way_en[src_s*WAYS +: WAYS] : '0;
  assign io_out_write  = out_valid_s ? io_req_write[src_s] : 1'b0;
  assign io_resp_valid = resp_valid_r;
  assign io_resp_src   = resp_src_r;

  // Next-state: everything holds unless the array accepts this cycle.
  always_comb begin
    state_n    = state_r;
    lock_src_n = lock_src_r;
    rr_ptr_n   = rr_ptr_r;
    beat_cnt_n = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          rr_ptr_n = src_s;
          if (io_req_burst[src_s]) begin
            state_n    = LOCKED;
            lock_src_n = src_s;
            beat_cnt_n = CNT_W'(1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (fire_s) begin
          if (beat_cnt_r == CNT_W'(BEATS - 1)) begin
            state_n    = IDLE;
            beat_cnt_n = '0;
            rr_ptr_n   = lock_src_r;
          end else begin
            beat_cnt_n = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          state_n = LOCKED;
        end
      end
      default: begin
        state_n    = IDLE;
        beat_cnt_n = '0;
      end
    endcase
  end

  // Scheduler state and the one-cycle-delayed read response tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      lock_src_r   <= '0;
      rr_ptr_r     <= SRC_W'(N_REQ - 1);
      beat_cnt_r   <= '0;
      resp_valid_r <= 1'b0;
      resp_src_r   <= '0;
    end else begin
      state_r      <= state_n;
      lock_src_r   <= lock_src_n;
      rr_ptr_r     <= rr_ptr_n;
      beat_cnt_r   <= beat_cnt_n;
      resp_valid_r <= fire_s & ~io_out_write;
      resp_src_r   <= src_s;
    end
  end

`ifdef DATA_SCHED_PERF_EN
  logic [3:0]  valid_cnt_s;
  logic        conflict_s;
  logic [15:0] perf_r;

  // Contention: two or more requesters, or anyone knocking on a locked port.
  always_comb begin
    valid_cnt_s = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      valid_cnt_s = valid_cnt_s + {3'd0, io_req_valid[i]};
    end
    conflict_s = (valid_cnt_s >= 4'd2) |
                 ((state_r == LOCKED) & (|(io_req_valid & ~lock_oh_s)));
  end

  // Saturating conflict counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_r <= 16'd0;
    end else if (conflict_s && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign io_perf_conflicts = perf_r;
`endif

endmodule

// File: tb/tb_dcache_data_sched.sv
// Directed bench for dcache_data_sched with a read-response scoreboard queue.
module tb_dcache_data_sched;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [35:0] req_addr;
  logic [23:0] req_way_en;
  logic [2:0]  req_write;
  logic [2:0]  req_burst;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic [7:0]  out_way_en;
  logic        out_write;
  logic [1:0]  out_src;
  logic        resp_valid;
  logic [1:0]  resp_src;
`ifdef DATA_SCHED_PERF_EN
  logic [15:0] perf_conflicts;
`endif

  logic [11:0] addr_v [0:2];
  logic [7:0]  way_v  [0:2];
  logic [1:0]  exp_q  [$];
  int          checks;
  int          errors;

  assign req_addr   = {addr_v[2], addr_v[1], addr_v[0]};
  assign req_way_en = {way_v[2], way_v[1], way_v[0]};

  dcache_data_sched dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_addr   (req_addr),
    .io_req_way_en (req_way_en),
    .io_req_write  (req_write),
    .io_req_burst  (req_burst),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_addr   (out_addr),
    .io_out_way_en (out_way_en),
    .io_out_write  (out_write),
    .io_out_src    (out_src),
    .io_resp_valid (resp_valid),
    .io_resp_src   (resp_src)
`ifdef DATA_SCHED_PERF_EN
    ,
    .io_perf_conflicts (perf_conflicts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check comb outputs and the scoreboard at negedge, then advance.
  task automatic cyc(input string tag, input logic ev, input logic [1:0] es,
                     input logic [2:0] erdy, input logic rd_fire);
    logic [1:0] e;
    @(negedge clock);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, ".out_src"}, {30'd0, out_src}, ev ? {30'd0, es} : 32'd0);
    check({tag, ".req_ready"}, {29'd0, req_ready}, {29'd0, erdy});
    check({tag, ".out_addr"}, {20'd0, out_addr}, ev ? {20'd0, addr_v[es]} : 32'd0);
    check({tag, ".out_way"}, {24'd0, out_way_en}, ev ? {24'd0, way_v[es]} : 32'd0);
    check({tag, ".out_write"}, {31'd0, out_write}, ev ? {31'd0, req_write[es]} : 32'd0);
    check({tag, ".resp_valid"}, {31'd0, resp_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".resp_src"}, {30'd0, resp_src}, {30'd0, e});
    end
    if (rd_fire) exp_q.push_back(es);
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    addr_v[0] = 12'h1A0; addr_v[1] = 12'h2B1; addr_v[2] = 12'h3C2;
    way_v[0]  = 8'h01;   way_v[1]  = 8'h12;   way_v[2]  = 8'h80;
    reset     = 1'b1;
    req_valid = 3'b000;
    req_write = 3'b000;
    req_burst = 3'b000;
    out_ready = 1'b1;
    #12;
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_src", {30'd0, resp_src}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Plain round robin over all three.
    req_valid = 3'b111;
    cyc("rr0", 1'b1, 2'd0, 3'b001, 1'b1);
    cyc("rr1", 1'b1, 2'd1, 3'b010, 1'b1);
    cyc("rr2", 1'b1, 2'd2, 3'b100, 1'b1);
    cyc("rr3", 1'b1, 2'd0, 3'b001, 1'b1);
    req_valid = 3'b000;
    cyc("rr_idle", 1'b0, 2'd0, 3'b000, 1'b0);

    // Fresh pointer, then stall with 0 and 2 requesting.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req_valid = 3'b101;
    out_ready = 1'b0;
    cyc("stall0", 1'b1, 2'd0, 3'b000, 1'b0);
    cyc("stall1", 1'b1, 2'd0, 3'b000, 1'b0);
    cyc("stall2", 1'b1, 2'd0, 3'b000, 1'b0);
    out_ready = 1'b1;
    cyc("stall_go0", 1'b1, 2'd0, 3'b001, 1'b1);
    cyc("stall_go2", 1'b1, 2'd2, 3'b100, 1'b1);

    // Burst write from requester 1 while 0 and 2 keep requesting.
    req_valid = 3'b001;
    cyc("pre_burst", 1'b1, 2'd0, 3'b001, 1'b1);
    req_valid = 3'b111;
    req_write = 3'b010;
    req_burst = 3'b010;
    cyc("bw0", 1'b1, 2'd1, 3'b010, 1'b0);
    cyc("bw1", 1'b1, 2'd1, 3'b010, 1'b0);
    cyc("bw2", 1'b1, 2'd1, 3'b010, 1'b0);
    cyc("bw3", 1'b1, 2'd1, 3'b010, 1'b0);
    req_write = 3'b000;
    req_burst = 3'b000;
    cyc("bw_after", 1'b1, 2'd2, 3'b100, 1'b1);

    // Owner drops valid mid-burst; the lock holds.
    req_valid = 3'b010;
    req_write = 3'b010;
    req_burst = 3'b010;
    cyc("gap0", 1'b1, 2'd1, 3'b010, 1'b0);
    req_valid = 3'b101;
    req_burst = 3'b000;
    cyc("gap_hold0", 1'b0, 2'd0, 3'b000, 1'b0);
    cyc("gap_hold1", 1'b0, 2'd0, 3'b000, 1'b0);
    req_valid = 3'b111;
    cyc("gap1", 1'b1, 2'd1, 3'b010, 1'b0);
    cyc("gap2", 1'b1, 2'd1, 3'b010, 1'b0);
    cyc("gap3", 1'b1, 2'd1, 3'b010, 1'b0);
    req_write = 3'b000;
    req_valid = 3'b101;
    cyc("gap_after", 1'b1, 2'd2, 3'b100, 1'b1);

    // Reset in the middle of a read burst.
    req_valid = 3'b010;
    req_burst = 3'b010;
    cyc("rb0", 1'b1, 2'd1, 3'b010, 1'b1);
    req_burst = 3'b000;
    cyc("rb1", 1'b1, 2'd1, 3'b010, 1'b1);
    check("rb.resp_pending", {31'd0, resp_valid}, 32'd1);
    req_valid = 3'b111;
    reset = 1'b1;
    #1;
    check("mid_rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst.out_src", {30'd0, out_src}, 32'd0);
    check("mid_rst.ready", {29'd0, req_ready}, 32'd1);
    exp_q.delete();
    #1;
    reset = 1'b0;
    cyc("post_rst0", 1'b1, 2'd0, 3'b001, 1'b1);
    cyc("post_rst1", 1'b1, 2'd1, 3'b010, 1'b1);
    req_valid = 3'b000;
    cyc("post_rst_idle", 1'b0, 2'd0, 3'b000, 1'b0);

`ifdef DATA_SCHED_PERF_EN
    req_valid = 3'b011;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("perf_conflicts", {16'd0, perf_conflicts}, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
